// File: rtl/addsub_sequencer_pkg.sv
// Shared constants for the add/sub accumulator sequencer: FSM state encoding
// and the operand values that make the datapath hold its current Z.
package addsub_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_FIRST  = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_ISSUE0 = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  // Hold op: Z <= Z + 0 through the feedback path, never overflows.
  localparam logic HOLD_SEL    = 1'b1;
  localparam logic HOLD_ADDSUB = 1'b0;

endpackage

// File: rtl/addsub_sequencer_if.sv
// Command, operand and result handshakes between a producer/consumer
// (master) and the sequencer (slave).
interface addsub_sequencer_if #(
  parameter int N = 16,
  parameter int C = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [C-1:0] cmd_count;
  logic         cmd_sub;
  logic         op_valid;
  logic         op_ready;
  logic [N-1:0] op_data;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_overflow;

  modport master (
    output cmd_valid, cmd_count, cmd_sub, op_valid, op_data, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data, res_overflow
  );

  modport slave (
    input  cmd_valid, cmd_count, cmd_sub, op_valid, op_data, res_ready,
    output cmd_ready, op_ready, res_valid, res_data, res_overflow
  );
endinterface

// File: rtl/addsub_datapath.sv
// Registered n-bit adder/subtractor accumulator: inputs registered, Z and
// signed Overflow registered; Sel=1 feeds Z back in place of A.
module addsub_datapath #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sel,
  input  logic         addsub,
  output logic [N-1:0] z,
  output logic         overflow
);
  logic [N-1:0] a_reg, b_reg, z_reg;
  logic         sel_reg, addsub_reg, overflow_reg;
  logic [N-1:0] opnd, result;
  logic         ovf_next;

  always_comb begin
    opnd   = sel_reg ? z_reg : a_reg;
    result = addsub_reg ? (opnd - b_reg) : (opnd + b_reg);
    if (addsub_reg)
      ovf_next = (opnd[N-1] != b_reg[N-1]) && (result[N-1] != opnd[N-1]);
    else
      ovf_next = (opnd[N-1] == b_reg[N-1]) && (result[N-1] != opnd[N-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      sel_reg      <= 1'b0;
      addsub_reg   <= 1'b0;
      z_reg        <= '0;
      overflow_reg <= 1'b0;
    end else begin
      a_reg        <= a;
      b_reg        <= b;
      sel_reg      <= sel;
      addsub_reg   <= addsub;
      z_reg        <= result;
      overflow_reg <= ovf_next;
    end
  end

  assign z        = z_reg;
  assign overflow = overflow_reg;
endmodule

// File: rtl/addsub_sequencer.sv
// Streams K operands of a command into one registered add/sub datapath,
// drains its two-stage pipeline and returns Z with a sticky overflow flag.
module addsub_sequencer
  import addsub_sequencer_pkg::*;
#(
  parameter int N = 16,
  parameter int C = 8
) (
  input  logic         clk,
  input  logic         rst,
  addsub_sequencer_if.slave bus,
  output logic [N-1:0] dp_a,
  output logic [N-1:0] dp_b,
  output logic         dp_sel,
  output logic         dp_addsub,
  input  logic [N-1:0] dp_z,
  input  logic         dp_overflow
);
  logic [2:0]   state_reg, state_next;
  logic [C-1:0] count_reg;
  logic [C-1:0] remaining_reg;
  logic         sub_reg;
  logic [N-1:0] op0_reg;
  logic         sticky_reg;
  logic         drain_reg;
  logic [N-1:0] res_data_reg;
  logic         res_overflow_reg;
  logic         op_ready;
  logic         op_fire;

  assign op_ready = (state_reg == ST_LOAD) || (state_reg == ST_FIRST) ||
                    (state_reg == ST_ISSUE);
  assign op_fire  = op_ready && bus.op_valid;

  assign bus.cmd_ready    = (state_reg == ST_IDLE);
  assign bus.op_ready     = op_ready;
  assign bus.res_valid    = (state_reg == ST_DONE);
  assign bus.res_data     = res_data_reg;
  assign bus.res_overflow = res_overflow_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (bus.cmd_valid)
                   state_next = (bus.cmd_count == '0) ? ST_ISSUE0 : ST_LOAD;
      ST_LOAD:   if (op_fire)
                   state_next = (count_reg == C'(1)) ? ST_ISSUE0 : ST_FIRST;
      ST_ISSUE0: state_next = ST_DRAIN;
      ST_FIRST:  if (op_fire)
                   state_next = (count_reg == C'(2)) ? ST_DRAIN : ST_ISSUE;
      ST_ISSUE:  if (op_fire && (remaining_reg == C'(1)))
                   state_next = ST_DRAIN;
      ST_DRAIN:  if (drain_reg) state_next = ST_DONE;
      ST_DONE:   if (bus.res_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Anything that is not a real operation falls through to the hold op.
  always_comb begin
    dp_a      = '0;
    dp_b      = '0;
    dp_sel    = HOLD_SEL;
    dp_addsub = HOLD_ADDSUB;
    case (state_reg)
      ST_ISSUE0: begin
        dp_a   = op0_reg;
        dp_sel = 1'b0;
      end
      ST_FIRST: if (bus.op_valid) begin
        dp_a      = op0_reg;
        dp_b      = bus.op_data;
        dp_sel    = 1'b0;
        dp_addsub = sub_reg;
      end
      ST_ISSUE: if (bus.op_valid) begin
        dp_b      = bus.op_data;
        dp_sel    = 1'b1;
        dp_addsub = sub_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      count_reg        <= '0;
      remaining_reg    <= '0;
      sub_reg          <= 1'b0;
      op0_reg          <= '0;
      sticky_reg       <= 1'b0;
      drain_reg        <= 1'b0;
      res_data_reg     <= '0;
      res_overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg != ST_IDLE)
        sticky_reg <= sticky_reg | dp_overflow;
      case (state_reg)
        ST_IDLE: if (bus.cmd_valid) begin
          count_reg  <= bus.cmd_count;
          sub_reg    <= bus.cmd_sub;
          op0_reg    <= '0;   // K=0 issues 0+0 from this register
          sticky_reg <= 1'b0;
          drain_reg  <= 1'b0;
        end
        ST_LOAD:  if (op_fire) op0_reg <= bus.op_data;
        ST_FIRST: if (op_fire) remaining_reg <= count_reg - C'(2);
        ST_ISSUE: if (op_fire) remaining_reg <= remaining_reg - C'(1);
        ST_DRAIN: begin
          drain_reg <= ~drain_reg;
          if (drain_reg) begin
            res_data_reg     <= dp_z;
            res_overflow_reg <= sticky_reg | dp_overflow;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
